// File: rtl/aimc_lib.sv
// Shared types and helpers for the ordering CAM.
// Entry lifecycle enum and a lowest-set-bit index helper.
package aimc_lib;

    localparam int ORDE_MAX_DEPTH = 256;

    typedef enum logic [1:0] {
        ORDE_FREE,
        ORDE_PEND,
        ORDE_MATCH
    } orde_entry_st_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int onehot_lowest(
        input logic [ORDE_MAX_DEPTH-1:0] v
    );
        int r;
        r = 0;
        for (int i = ORDE_MAX_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/orde_cam_age_matrix.sv
// Older-than matrix: older[r][c] means entry r was inserted before c.
// Picks the one candidate that no other candidate predates.
module orde_cam_age_matrix #(
    parameter int CAM_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CAM_DEPTH-1:0] ins_oh,
    input  logic [CAM_DEPTH-1:0] free_oh,
    input  logic [CAM_DEPTH-1:0] cand,
    output logic [CAM_DEPTH-1:0] oldest
);

    logic [CAM_DEPTH-1:0] older [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] nxt   [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] blk;

    // New entry: its row clears, every other row gains its column.
    // Freed entries drop both row and column.
    always_comb begin
        for (int r = 0; r < CAM_DEPTH; r++) begin
            for (int c = 0; c < CAM_DEPTH; c++) begin
                nxt[r][c] = older[r][c];
                if (ins_oh[r]) nxt[r][c] = 1'b0;
                if (ins_oh[c] && (r != c)) nxt[r][c] = 1'b1;
                if (free_oh[r] || free_oh[c]) nxt[r][c] = 1'b0;
            end
        end
    end

    // Matrix register, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < CAM_DEPTH; r++) older[r] <= '0;
        end else begin
            for (int r = 0; r < CAM_DEPTH; r++) older[r] <= nxt[r];
        end
    end

    // A candidate is oldest when no other candidate is older than it.
    always_comb begin
        blk = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            for (int j = 0; j < CAM_DEPTH; j++) begin
                if (j != i) blk[i] = blk[i] | (cand[j] & older[j][i]);
            end
        end
        oldest = cand & ~blk;
    end

endmodule

// File: rtl/orde_cam_alloc.sv
// Ordering CAM with self-allocation, FREE/PEND/MATCH lifecycle, oldest-hit.
// ORDE_CAM_TERNARY_EN adds srch_mask (0 bits are don't-care on compare).
module orde_cam_alloc
    import aimc_lib::*;
#(
    parameter  int CAM_DEPTH = 32,
    parameter  int CAM_WIDTH = 23,
    localparam int IDX_W     = $clog2(CAM_DEPTH),
    localparam int CNT_W     = $clog2(CAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    input  logic [CAM_WIDTH-1:0] ins_key,
    output logic                 ins_ready,
    output logic [IDX_W-1:0]     ins_idx,
    input  logic                 srch_valid,
    input  logic [CAM_WIDTH-1:0] srch_key,
`ifdef ORDE_CAM_TERNARY_EN
    input  logic [CAM_WIDTH-1:0] srch_mask,
`endif
    output logic                 srch_hit,
    output logic [IDX_W-1:0]     srch_idx,
    output logic [CAM_DEPTH-1:0] match_entry_array,
    input  logic                 claim_valid,
    input  logic [IDX_W-1:0]     claim_idx,
    input  logic                 stat_valid,
    input  logic [IDX_W-1:0]     stat_idx,
    output logic                 status,
    input  logic                 pop_valid,
    input  logic [IDX_W-1:0]     pop_idx,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    orde_entry_st_t       st   [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] keys [CAM_DEPTH];

    logic [CAM_WIDTH-1:0] cmp_mask;
    logic [CAM_DEPTH-1:0] free_v, pend_v, hit_v;
    logic [CAM_DEPTH-1:0] claim_oh, ins_oh, pop_oh;
    logic [CAM_DEPTH-1:0] elig, oldest;
    logic [ORDE_MAX_DEPTH-1:0] free_x, old_x;
    logic ins_acc, claim_ok, pop_ok, clash, bad;

`ifdef ORDE_CAM_TERNARY_EN
    assign cmp_mask = srch_mask;
`else
    assign cmp_mask = '1;
`endif

    // Per-entry state decode and key compare.
    always_comb begin
        free_v = '0;
        pend_v = '0;
        hit_v  = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            free_v[i] = (st[i] == ORDE_FREE);
            pend_v[i] = (st[i] == ORDE_PEND);
            hit_v[i]  = (((keys[i] ^ srch_key) & cmp_mask) == '0);
        end
    end

    // Zero-extend vectors for the shared index helper.
    always_comb begin
        free_x = '0;
        old_x  = '0;
        free_x[CAM_DEPTH-1:0] = free_v;
        old_x[CAM_DEPTH-1:0]  = oldest;
    end

    assign ins_ready = !full;
    assign ins_idx   = IDX_W'(onehot_lowest(free_x));
    assign ins_acc   = ins_valid && ins_ready;
    assign ins_oh    = ins_acc ? (CAM_DEPTH'(1) << ins_idx) : '0;

    assign claim_ok = claim_valid && (st[claim_idx] == ORDE_PEND);
    assign claim_oh = claim_valid ? (CAM_DEPTH'(1) << claim_idx) : '0;
    assign clash    = claim_valid && pop_valid && (claim_idx == pop_idx);
    assign pop_ok   = pop_valid && (st[pop_idx] == ORDE_MATCH) && !clash;
    assign pop_oh   = pop_ok ? (CAM_DEPTH'(1) << pop_idx) : '0;
    assign bad      = (claim_valid && !claim_ok) || (pop_valid && !pop_ok);

    // An entry being claimed this cycle is no longer a search candidate.
    assign elig = pend_v & hit_v & ~claim_oh & {CAM_DEPTH{srch_valid}};

    assign match_entry_array = elig;
    assign srch_hit          = |elig;
    assign srch_idx          = IDX_W'(onehot_lowest(old_x));

    assign status = stat_valid && (st[stat_idx] == ORDE_MATCH);
    assign full   = (count == CNT_W'(CAM_DEPTH));
    assign empty  = (count == '0);

    orde_cam_age_matrix #(
        .CAM_DEPTH (CAM_DEPTH)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .ins_oh  (ins_oh),
        .free_oh (pop_oh),
        .cand    (elig),
        .oldest  (oldest)
    );

    // Lifecycle: insert, claim and pop always hit distinct entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CAM_DEPTH; i++) st[i] <= ORDE_FREE;
        end else begin
            if (ins_acc)  st[ins_idx]   <= ORDE_PEND;
            if (claim_ok) st[claim_idx] <= ORDE_MATCH;
            if (pop_ok)   st[pop_idx]   <= ORDE_FREE;
        end
    end

    // Key storage carries no reset; state gates its use.
    always_ff @(posedge clk) begin
        if (ins_acc) keys[ins_idx] <= ins_key;
    end

    // Occupancy counter and registered protocol-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= bad;
            unique case ({ins_acc, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
